// File: rtl/radiant_event_hdr_reader_if.sv
// Wishbone read master and header word stream bundled for the event header reader.
// The master modport is the reader side; the slave modport is the bus/stream partner side.
interface radiant_event_hdr_reader_if;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [8:0]  wbm_adr;
    logic [31:0] wbm_dat;
    logic        wbm_ack;
    logic [31:0] hdr_tdata;
    logic        hdr_tvalid;
    logic        hdr_tlast;
    logic        hdr_tready;

    modport master (
        output wbm_cyc,
        output wbm_stb,
        output wbm_we,
        output wbm_sel,
        output wbm_adr,
        input  wbm_dat,
        input  wbm_ack,
        output hdr_tdata,
        output hdr_tvalid,
        output hdr_tlast,
        input  hdr_tready
    );

    modport slave (
        input  wbm_cyc,
        input  wbm_stb,
        input  wbm_we,
        input  wbm_sel,
        input  wbm_adr,
        output wbm_dat,
        output wbm_ack,
        input  hdr_tdata,
        input  hdr_tvalid,
        input  hdr_tlast,
        output hdr_tready
    );
endinterface

// File: rtl/radiant_event_hdr_reader.sv
// Reads NumDwords header words per pending event over Wishbone (one transfer per cycle
// of cyc) and forwards them as a framed 32-bit stream, with pending/overflow/error tracking.
module radiant_event_hdr_reader #(
    parameter int unsigned NumDwords = 8,
    parameter logic [8:0]  BaseAddr  = 9'h100,
    parameter logic [31:0] Ident     = 32'h52444530,
    parameter int unsigned Timeout   = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              enable_i,
    input  logic                              clear_i,
    input  logic                              event_flag_i,
    radiant_event_hdr_reader_if.master        bus,
    output logic [4:0]                        pending_o,
    output logic                              busy_o,
    output logic                              overflow_o,
    output logic                              ident_err_o,
    output logic                              timeout_err_o
);

    localparam int unsigned IdxW   = (NumDwords > 1) ? $clog2(NumDwords) : 1;
    localparam int unsigned TimerW = $clog2(Timeout + 1);
    localparam logic [4:0]  PendMax = 5'd16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StPush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [31:0]       hold_q, hold_d;
    logic [4:0]        pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              ident_err_q, ident_err_d;
    logic              timeout_err_q, timeout_err_d;

    logic last_word;
    logic ack_take;
    logic timeout_hit;
    logic frame_done;
    logic overflow_set;
    logic ident_set;

    always_comb begin
        last_word   = (idx_q == IdxW'(NumDwords - 1));
        ack_take    = (state_q == StReq) && bus.wbm_ack;
        // Ack in the final allowed cycle still counts as a good read.
        timeout_hit = (state_q == StReq) && !bus.wbm_ack && (timer_q == TimerW'(Timeout - 1));
        frame_done  = (state_q == StDone);
        ident_set   = ack_take && (idx_q == '0) && (bus.wbm_dat != Ident);
    end

    // Frame sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = '0;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (enable_i && (pending_q != 5'd0)) begin
                    state_d = StReq;
                    idx_d   = '0;
                end
            end
            StReq: begin
                if (ack_take) begin
                    hold_d  = bus.wbm_dat;
                    state_d = StPush;
                end else if (timeout_hit) begin
                    hold_d  = 32'hFFFF_FFFF;
                    state_d = StPush;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StPush: begin
                if (bus.hdr_tready) begin
                    if (last_word) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pending headers: simultaneous arrival and completion cancel out.
    always_comb begin
        pending_d    = pending_q;
        overflow_set = 1'b0;
        case ({event_flag_i, frame_done})
            2'b10: begin
                if (pending_q == PendMax) begin
                    overflow_set = 1'b1;
                end else begin
                    pending_d = pending_q + 5'd1;
                end
            end
            2'b01: begin
                if (pending_q != 5'd0) begin
                    pending_d = pending_q - 5'd1;
                end
            end
            default: begin
                pending_d = pending_q;
            end
        endcase
    end

    always_comb begin
        overflow_d    = overflow_set | (overflow_q & ~clear_i);
        ident_err_d   = ident_set | (ident_err_q & ~clear_i);
        timeout_err_d = timeout_hit | (timeout_err_q & ~clear_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            timer_q       <= '0;
            hold_q        <= '0;
            pending_q     <= 5'd0;
            overflow_q    <= 1'b0;
            ident_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            hold_q        <= hold_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            ident_err_q   <= ident_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign bus.wbm_cyc    = (state_q == StReq);
    assign bus.wbm_stb    = (state_q == StReq);
    assign bus.wbm_we     = 1'b0;
    assign bus.wbm_sel    = 4'hF;
    assign bus.wbm_adr    = (state_q == StReq) ? (BaseAddr + 9'({idx_q, 2'b00})) : 9'h000;
    assign bus.hdr_tvalid = (state_q == StPush);
    assign bus.hdr_tdata  = (state_q == StPush) ? hold_q : 32'h0;
    assign bus.hdr_tlast  = (state_q == StPush) && last_word;

    assign pending_o     = pending_q;
    assign busy_o        = (state_q != StIdle);
    assign overflow_o    = overflow_q;
    assign ident_err_o   = ident_err_q;
    assign timeout_err_o = timeout_err_q;

endmodule
